// File: rtl/ctrl_req_arbiter.sv
// ctrl_req_arbiter: round-robin sharing of the controller command path with in-order read-data return routing
module ctrl_req_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init_done,
  input  logic                             refresh_pend,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_rw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic                             cmd_rw,
  output logic [ADDR_WIDTH-1:0]            cmd_addr,
  output logic [DATA_WIDTH-1:0]            cmd_wdata,
  output logic [$clog2(NUM_PORTS)-1:0]     cmd_port,
  input  logic                             rd_valid_in,
  input  logic [DATA_WIDTH-1:0]            rd_data_in,
  output logic [NUM_PORTS-1:0]             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             tag_full,
  output logic                             tag_err
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int TW = $clog2(TAG_DEPTH);
  localparam logic [TW:0] FULL = (TW+1)'(TAG_DEPTH);
  typedef enum logic {ARB, ISSUE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, win_idx, cmd_port_q, cmd_port_d;
  logic [PW-1:0] tag_mem_q [TAG_DEPTH];
  logic [TW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TW:0] count_q, count_d;
  logic [NUM_PORTS-1:0] elig, rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d, rd_data_q, rd_data_d;
  logic cmd_rw_q, cmd_rw_d, tag_full_q, tag_full_d, tag_err_q, tag_err_d;
  logic win_found, accept, fire, push, pop;
  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      elig[p] = req_valid[p] & init_done & ~refresh_pend & (~req_rw[p] | (count_q != FULL));
    win_found = 1'b0;
    win_idx = '0;
    // Scan downward so the port closest to rr_ptr is the last, and winning, assignment
    for (int i = NUM_PORTS-1; i >= 0; i--)
      if (elig[(int'(rr_ptr_q) + i) % NUM_PORTS]) begin
        win_found = 1'b1;
        win_idx = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
      end
    accept = state_q == ARB && win_found;
    fire = state_q == ISSUE && cmd_ready;
    push = fire && cmd_rw_q;
    pop = rd_valid_in && count_q != '0;
    req_ready = accept ? NUM_PORTS'(1) << win_idx : '0;
    state_d = accept ? ISSUE : fire ? ARB : state_q;
    cmd_rw_d = accept ? req_rw[win_idx] : cmd_rw_q;
    cmd_addr_d = accept ? req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH] : cmd_addr_q;
    cmd_wdata_d = accept ? req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH] : cmd_wdata_q;
    cmd_port_d = accept ? win_idx : cmd_port_q;
    rr_ptr_d = !fire ? rr_ptr_q : cmd_port_q == PW'(NUM_PORTS-1) ? '0 : cmd_port_q + PW'(1);
    wr_ptr_d = wr_ptr_q + TW'(push);
    rd_ptr_d = rd_ptr_q + TW'(pop);
    count_d = count_q + (TW+1)'(push) - (TW+1)'(pop);
    tag_full_d = count_d == FULL;
    rd_valid_d = pop ? NUM_PORTS'(1) << tag_mem_q[rd_ptr_q] : '0;
    rd_data_d = pop ? rd_data_in : rd_data_q;
    tag_err_d = tag_err_q | (rd_valid_in & ~pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      rr_ptr_q <= '0;
      cmd_rw_q <= 1'b0;
      cmd_addr_q <= '0;
      cmd_wdata_q <= '0;
      cmd_port_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      tag_full_q <= 1'b0;
      rd_valid_q <= '0;
      rd_data_q <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cmd_rw_q <= cmd_rw_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_port_q <= cmd_port_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      tag_full_q <= tag_full_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      tag_err_q <= tag_err_d;
    end
  end
  always_ff @(posedge clk)
    if (push) tag_mem_q[wr_ptr_q] <= cmd_port_q;
  assign cmd_valid = state_q == ISSUE;
  assign cmd_rw = cmd_rw_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign cmd_port = cmd_port_q;
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign tag_full = tag_full_q;
  assign tag_err = tag_err_q;
endmodule
